// File: rtl/fetch_pc_gen_pkg.sv
// fetch_pc_gen_pkg: shared constants and types for the fetch PC generator.
// Imported by redirect_hold and fetch_pc_gen.
package fetch_pc_gen_pkg;

  localparam int BR_WD = 33;

  localparam logic [31:0] RESET_PC_DEF = 32'hbfc0_0000;

  typedef enum logic [1:0] {
    SRC_SEQ = 2'd0,
    SRC_BR  = 2'd1,
    SRC_BP  = 2'd2
  } src_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } redir_t;

  function automatic logic [31:0] align_pc(
    input logic [31:0] a,
    input int unsigned lg
  );
    return a & ~((32'd1 << lg) - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_pc_gen_redirect_hold.sv
// redirect_hold: one pending {valid, addr} redirect register.
// set loads only when empty, ovr always loads, clr wins over both.
module redirect_hold
  import fetch_pc_gen_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             set_i,
  input  logic             ovr_i,
  input  logic             clr_i,
  input  logic [31:0]      addr_i,
  output logic [BR_WD-1:0] hold_o
);

  redir_t hold_d;
  redir_t hold_q;

  always_comb begin
    hold_d = hold_q;
    if (clr_i) begin
      hold_d = '0;
    end else if (ovr_i || (set_i && !hold_q.valid)) begin
      hold_d.valid = 1'b1;
      hold_d.addr  = addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign hold_o = hold_q;

endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch-group PC, redirect select and fetch request issue.
// Define FETCH_BP_EN to enable the branch-predictor redirect path.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int unsigned FETCH_W  = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned EPOCH_W  = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  stall,
  input  logic                  br_valid,
  input  logic [31:0]           br_addr,
  input  logic                  bp_valid,
  input  logic [31:0]           bp_addr,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [31:0]           req_addr,
  output logic [FETCH_W-1:0]    req_mask,
  output logic [EPOCH_W-1:0]    req_epoch,
  output logic [32*FETCH_W-1:0] seq_pc
);

  localparam int unsigned LG = $clog2(FETCH_W) + 2;
  localparam logic [31:0] G  = 32'(4 * FETCH_W);
  localparam logic [31:0] RST_PC = align_pc(RESET_PC, LG);

  function automatic logic [FETCH_W-1:0] slot_mask(
    input logic [31:0] a
  );
    logic [31:0]        off;
    logic [FETCH_W-1:0] full;
    off  = (a >> 2) & 32'(FETCH_W - 1);
    full = '1;
    return full << off;
  endfunction

  logic [31:0]        pc_d, pc_q;
  logic [FETCH_W-1:0] mask_d, mask_q;
  logic [EPOCH_W-1:0] epoch_d, epoch_q;
  logic               req_valid_d, req_valid_q;

  logic        adv;
  src_e        src;
  logic [31:0] sel;
  logic        kill;
  logic        br_ovr;
  redir_t      pbr;

  assign adv    = !stall && (req_ready || !req_valid_q);
  assign br_ovr = !adv && br_valid;

  redirect_hold u_br_hold (
    .clk    (clk),
    .resetn (resetn),
    .set_i  (1'b0),
    .ovr_i  (br_ovr),
    .clr_i  (adv),
    .addr_i (br_addr),
    .hold_o (pbr)
  );

`ifdef FETCH_BP_EN
  redir_t pbp;
  logic   bp_set;
  logic   bp_clr;

  assign bp_set = !adv && bp_valid && !br_valid && !pbr.valid;
  assign bp_clr = adv || br_ovr;

  redirect_hold u_bp_hold (
    .clk    (clk),
    .resetn (resetn),
    .set_i  (bp_set),
    .ovr_i  (1'b0),
    .clr_i  (bp_clr),
    .addr_i (bp_addr),
    .hold_o (pbp)
  );

  assign kill = br_valid || pbr.valid || bp_valid || pbp.valid;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_valid, bp_addr};
  assign kill      = br_valid || pbr.valid;
`endif

  // Before the first request nothing at pc_q has issued yet, so do not skip it.
  always_comb begin
    src = SRC_SEQ;
    sel = req_valid_q ? pc_q + G : pc_q;
    if (pbr.valid) begin
      src = SRC_BR;
      sel = pbr.addr;
    end else if (br_valid) begin
      src = SRC_BR;
      sel = br_addr;
    end
`ifdef FETCH_BP_EN
    else if (pbp.valid) begin
      src = SRC_BP;
      sel = pbp.addr;
    end else if (bp_valid) begin
      src = SRC_BP;
      sel = bp_addr;
    end
`endif
  end

  always_comb begin
    pc_d        = pc_q;
    mask_d      = mask_q;
    epoch_d     = epoch_q;
    req_valid_d = req_valid_q;
    if (adv) begin
      pc_d        = align_pc(sel, LG);
      mask_d      = (src == SRC_SEQ) ? '1 : slot_mask(sel);
      req_valid_d = 1'b1;
      if (src == SRC_BR) begin
        epoch_d = epoch_q + EPOCH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q        <= RST_PC;
      mask_q      <= '1;
      epoch_q     <= '0;
      req_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      mask_q      <= mask_d;
      epoch_q     <= epoch_d;
      req_valid_q <= req_valid_d;
    end
  end

  assign req_valid = req_valid_q;
  assign req_addr  = pc_q;
  assign req_mask  = mask_q;
  assign req_epoch = epoch_q;

  for (genvar i = 0; i < FETCH_W; i++) begin : g_seq
    assign seq_pc[32*i +: 32] = kill ? 32'd0 : pc_q + G + 32'(4 * i);
  end

endmodule
